// File: rtl/mem_word_access_pkg.sv
// mem_word_access_pkg: state encodings, access-size codes and default
// geometry shared by the byte-wide RAM word-access initiator.
package mem_word_access_pkg;

  localparam int unsigned ADDR_WIDTH_DEF   = 12;
  localparam int unsigned READ_LATENCY_DEF = 1;
  localparam int unsigned READ_LATENCY_MAX = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_LO      = 3'd1,
    ST_WR_HI      = 3'd2,
    ST_RD_LO      = 3'd3,
    ST_RD_LO_WAIT = 3'd4,
    ST_RD_HI      = 3'd5,
    ST_RD_HI_WAIT = 3'd6,
    ST_DONE       = 3'd7
  } state_e;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_WORD = 1'b1
  } size_e;

  // Wait counter counts down from lat-1 to 0, so a
  // *_WAIT state lasts exactly lat cycles.
  function automatic logic [1:0] wait_reload(
    input int unsigned lat
  );
    if (lat == 0)
      return 2'd0;
    else if (lat > READ_LATENCY_MAX)
      return 2'(READ_LATENCY_MAX - 1);
    else
      return 2'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_word_access.sv
// mem_word_access: CPU byte/word load-store initiator for the byte-wide
// on-chip RAM; word accesses split into two little-endian byte cycles.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   req               start access (sampled only in IDLE)
//   is_write/is_word  direction / size, sampled with req
//   address, wdata    byte address and store data, sampled with req
//   busy, done        handshake status, done is a 1-cycle pulse
//   rdata, fault      load result (byte zero-extended), fault with done
//   mem_*             RAM port: address, write data, read data, strobe
//
// Build option: MEM_ALIGN_FAULT_EN makes odd-address word accesses
// finish immediately with fault=1 and no RAM activity.
module mem_word_access
  import mem_word_access_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  is_write,
  input  logic                  is_word,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [15:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           rdata,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data_out,
  input  logic [7:0]            mem_data_in,
  output logic                  mem_write_enable
);

  localparam logic [1:0] WAIT_RELOAD =
    wait_reload(READ_LATENCY);

  state_e                  state_q;
  size_e                   size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              wdata_hi_q;
  logic [1:0]              wait_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    we_q;
  logic [15:0]             rdata_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [7:0]              mem_dout_q;

  logic [ADDR_WIDTH-1:0]   addr_hi_d;
  logic                    wait_last_d;
  logic                    misalign_d;
  size_e                   size_d;

  // High byte lives at addr+1, wrapping at the top of RAM.
  assign addr_hi_d   = addr_q + ADDR_WIDTH'(1);
  assign wait_last_d = (wait_q == 2'd0);
  assign size_d      = is_word ? SZ_WORD : SZ_BYTE;

`ifdef MEM_ALIGN_FAULT_EN
  assign misalign_d = is_word & address[0];
`else
  assign misalign_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_hi_q <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            busy_q     <= 1'b1;
            size_q     <= size_d;
            addr_q     <= address;
            wdata_hi_q <= wdata[15:8];
            if (misalign_d) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (is_write) begin
              state_q    <= ST_WR_LO;
              mem_addr_q <= address;
              mem_dout_q <= wdata[7:0];
              we_q       <= 1'b1;
            end else begin
              state_q    <= ST_RD_LO;
              mem_addr_q <= address;
            end
          end
        end

        ST_WR_LO: begin
          if (size_q == SZ_WORD) begin
            state_q    <= ST_WR_HI;
            mem_addr_q <= addr_hi_d;
            mem_dout_q <= wdata_hi_q;
            we_q       <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        ST_WR_HI: begin
          state_q <= ST_DONE;
          we_q    <= 1'b0;
          done_q  <= 1'b1;
        end

        ST_RD_LO: begin
          state_q <= ST_RD_LO_WAIT;
          wait_q  <= WAIT_RELOAD;
        end

        ST_RD_LO_WAIT: begin
          if (wait_last_d) begin
            // Byte loads zero-extend, so the high half
            // is cleared here for both sizes.
            rdata_q <= {8'h00, mem_data_in};
            if (size_q == SZ_WORD) begin
              state_q    <= ST_RD_HI;
              mem_addr_q <= addr_hi_d;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end

        ST_RD_HI: begin
          state_q <= ST_RD_HI_WAIT;
          wait_q  <= WAIT_RELOAD;
        end

        ST_RD_HI_WAIT: begin
          if (wait_last_d) begin
            rdata_q[15:8] <= mem_data_in;
            state_q       <= ST_DONE;
            done_q        <= 1'b1;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_FAULT_EN
  logic fault_q;

  // Only the misaligned accept path enters DONE
  // directly, so fault is high exactly in that DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault_q <= 1'b0;
    else
      fault_q <= (state_q == ST_IDLE) && req && misalign_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign busy             = busy_q;
  assign done             = done_q;
  assign rdata            = rdata_q;
  assign mem_address      = mem_addr_q;
  assign mem_data_out     = mem_dout_q;
  assign mem_write_enable = we_q;

endmodule
